// File: rtl/fir_tb_pkg.sv
// Shared constants and state encoding for the FIR stimulus source.
package fir_tb_pkg;

    localparam int unsigned NB    = 8;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StGap,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/fir_stream_source_if.sv
// Sample stream presented to the FIR input: data, valid strobe and source index.
interface fir_stream_source_if;
    import fir_tb_pkg::*;

    logic [NB-1:0] dout;
    logic          vout;
    logic [AW-1:0] sample_idx;

    modport master (output dout, vout, sample_idx);
    modport slave  (input  dout, vout, sample_idx);

endinterface

// File: rtl/fir_src_mem.sv
// Sample RAM: one write port, one read port whose data register feeds DOUT directly.
module fir_src_mem
    import fir_tb_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [NB-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [NB-1:0] rd_data_o
);

    logic [NB-1:0] mem_q [DEPTH];
    logic [NB-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_stream_source.sv
// Plays a preloaded sample memory out as a valid-strobed stream with gap, pause and drain.
module fir_stream_source
    import fir_tb_pkg::*;
#(
    parameter int unsigned GW           = 4,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [NB-1:0]       wr_data_i,
    input  logic [AW:0]         num_samples_i,
    input  logic [GW-1:0]       gap_i,
    input  logic                start_i,
    input  logic                pause_i,
    fir_stream_source_if.master stream_o,
    output logic                busy_o,
    output logic                end_sim_o
);

    localparam int unsigned DcW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW:0] NMax = {1'b1, {AW{1'b0}}};

    state_e         state_q, state_d;
    logic [AW:0]    emit_q, emit_d;  // samples emitted so far; low bits are the read address
    logic [AW:0]    n_q, n_d;
    logic [GW-1:0]  g_q, g_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DcW-1:0] drain_cnt_q, drain_cnt_d;
    logic           vout_q, vout_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           mem_we, rd_en;
    logic [AW:0]    n_clamp;
    logic [NB-1:0]  dout;

    assign n_clamp = (num_samples_i > NMax) ? NMax : num_samples_i;

    always_comb begin
        state_d     = state_q;
        emit_d      = emit_q;
        n_d         = n_q;
        g_d         = g_q;
        gap_cnt_d   = gap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vout_d      = 1'b0;
        idx_d       = idx_q;
        mem_we      = 1'b0;
        rd_en       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                mem_we = wr_en_i;
                if (start_i) begin
                    n_d         = n_clamp;
                    g_d         = gap_i;
                    emit_d      = '0;
                    gap_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = (n_clamp == '0) ? StDrain : StPlay;
                end
            end
            StPlay: begin
                if (!pause_i) begin
                    rd_en  = 1'b1;
                    vout_d = 1'b1;
                    idx_d  = emit_q[AW-1:0];
                    emit_d = emit_q + 1'b1;
                    if (emit_d == n_q) begin
                        state_d = StDrain;
                    end else if (g_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end
                end
            end
            StGap: begin
                if (!pause_i) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == g_q) begin
                        state_d = StPlay;
                    end
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DcW'(DRAIN_CYCLES - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            emit_q      <= '0;
            n_q         <= '0;
            g_q         <= '0;
            gap_cnt_q   <= '0;
            drain_cnt_q <= '0;
            vout_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            emit_q      <= emit_d;
            n_q         <= n_d;
            g_q         <= g_d;
            gap_cnt_q   <= gap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vout_q      <= vout_d;
            idx_q       <= idx_d;
        end
    end

    fir_src_mem u_mem (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en),
        .rd_addr_i (emit_q[AW-1:0]),
        .rd_data_o (dout)
    );

    assign stream_o.dout       = dout;
    assign stream_o.vout       = vout_q;
    assign stream_o.sample_idx = idx_q;
    assign busy_o    = (state_q == StPlay) || (state_q == StGap) || (state_q == StDrain);
    assign end_sim_o = (state_q == StDone);

endmodule

// File: tb/tb_fir_stream_source.sv
// Scoreboard bench: expected samples and their edge numbers come from a reference schedule.
module tb_fir_stream_source;
    import fir_tb_pkg::*;

    localparam int DRAIN = 16;

    typedef struct {
        int            cyc;
        logic [NB-1:0] data;
        logic [AW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NB-1:0] wr_data = '0;
    logic [AW:0]   num = '0;
    logic [3:0]    gap = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          busy, end_sim;

    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    logic [NB-1:0] mem_model [DEPTH];
    logic [NB-1:0] last_dout = '0;
    logic [AW-1:0] last_idx = '0;
    exp_t          sb [$];

    fir_stream_source_if sif ();

    fir_stream_source #(
        .GW           (4),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .num_samples_i (num),
        .gap_i         (gap),
        .start_i       (start),
        .pause_i       (pause),
        .stream_o      (sif),
        .busy_o        (busy),
        .end_sim_o     (end_sim)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid must match the head of the scoreboard; DOUT/SAMPLE_IDX hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.vout) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got dout 0x%0h idx %0d, expected no valid",
                             sif.dout, sif.sample_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_edge", edge_cnt, e.cyc);
                    chk("dout", sif.dout, e.data);
                    chk("sample_idx", sif.sample_idx, e.idx);
                    last_dout = e.data;
                    last_idx  = e.idx;
                end
            end else begin
                chk("dout_hold", sif.dout, last_dout);
                chk("idx_hold", sif.sample_idx, last_idx);
            end
        end
    end

    // pmode: 0 no pause, 1 random pause, 2 pause on edges k+3..k+5. abort_r>0 resets mid-run.
    task automatic run(input int n_req, input int g, input int pmode, input bit sim_wr,
                       input int abort_r);
        int   n, r, need, last, end_r, k, wa;
        int   rel [$];
        bit   pz [$];
        logic [NB-1:0] wd;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        for (int i = 0; i < (n * (g + 1) + 8) * 6 + 64; i++) begin
            if (pmode == 1) pz.push_back($urandom_range(0, 3) == 0);
            else if (pmode == 2) pz.push_back(i >= 3 && i <= 5);
            else pz.push_back(1'b0);
        end
        wa = $urandom_range(0, (n > 0) ? n - 1 : 0);
        wd = NB'($urandom);
        if (sim_wr) mem_model[wa] = wd;
        r = 0;
        for (int i = 0; i < n; i++) begin
            need = (i == 0) ? 1 : g + 1;
            while (need > 0 && r < pz.size() - 1) begin
                r++;
                if (!pz[r]) need--;
            end
            if (need > 0) begin
                checks++;
                errors++;
                $display("FAIL pause_plan: got overflow, expected schedule to fit");
            end
            rel.push_back(r);
        end
        last  = r;
        end_r = last + DRAIN;
        @(negedge clk);
        k = edge_cnt + 1;
        for (int i = 0; i < n; i++) sb.push_back('{k + rel[i], mem_model[i], AW'(i)});
        start   = 1'b1;
        num     = (AW + 1)'(n_req);
        gap     = 4'(g);
        pause   = pz[0];
        wr_en   = sim_wr;
        wr_addr = AW'(wa);
        wr_data = wd;
        for (int rr = 1; rr <= end_r + 1; rr++) begin
            @(negedge clk);
            chk("busy", busy, (rr - 1) < end_r);
            chk("end_sim", end_sim, (rr - 1) >= end_r);
            if (rr <= end_r) begin
                pause   = (rr < pz.size()) ? pz[rr] : 1'b0;
                start   = ($urandom_range(0, 7) == 0);
                num     = (AW + 1)'($urandom);
                gap     = 4'($urandom);
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = AW'($urandom);
                wr_data = NB'($urandom);
            end else begin
                pause = 1'b0;
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (rr == abort_r) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_vout", sif.vout, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_end_sim", end_sim, 1'b0);
                chk("rst_dout", sif.dout, '0);
                chk("rst_idx", sif.sample_idx, '0);
                sb.delete();
                last_dout = '0;
                last_idx  = '0;
                start = 1'b0;
                wr_en = 1'b0;
                pause = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("all_valids_seen", sb.size(), 0);
        if (n > 0) chk("final_idx", sif.sample_idx, n - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_vout", sif.vout, 1'b0);
        chk("reset_dout", sif.dout, '0);
        chk("reset_idx", sif.sample_idx, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_end_sim", end_sim, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            logic [31:0] init4;
            init4 = 32'hFF80_7F01;
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = (a < 4) ? init4[a*8 +: 8] : NB'($urandom);
            mem_model[a] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;

        run(4, 0, 0, 0, 0);
        run(4, 2, 0, 0, 0);
        run(4, 0, 2, 0, 0);
        run(0, 0, 0, 0, 0);
        run(4, 0, 0, 0, 0);
        run(DEPTH + 5, 0, 0, 0, 0);
        run(4, 1, 0, 0, 0);
        run(3, 0, 0, 1, 0);
        for (int t = 0; t < 10; t++) begin
            run($urandom_range(0, 24), $urandom_range(0, 15), 1, 1'($urandom), 0);
        end
        run(4, 3, 0, 0, 3);
        run(4, 0, 0, 0, 0);
        run(6, 2, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_stream_source.md
Name: fir_stream_source

Overview:
- Synthesizable stimulus transmitter for the FIR datapath: it drives the DIN/VIN side that the filter receives on.
- Plays back a preloaded sample memory as an NB-bit stream with a valid strobe, using a programmable idle gap between samples and an external pause.
- Raises END_SIM after a drain window so the clock/reset generator can stop.
- Used in FPGA bring-up and in benches instead of file-based readers.

Parameters:
NB, 8, sample width (matches FIR DIN)
AW, 10, sample memory address width; depth = 2**AW
GW, 4, gap counter width
DRAIN_CYCLES, 16, idle cycles after last sample before END_SIM (must be >= FIR latency)

Ports:
CLK  in  1  system clock, rising edge
RST_n  in  1  asynchronous active-low reset
WR_EN  in  1  sample memory write strobe (honoured only when BUSY=0)
WR_ADDR  in  AW  sample memory write address
WR_DATA  in  NB  sample memory write data
NUM_SAMPLES  in  AW+1  number of samples to play, sampled on accepted START
GAP  in  GW  idle cycles inserted after each valid sample, sampled on accepted START
START  in  1  start pulse
PAUSE  in  1  level; freezes playback while high
DOUT  out  NB  sample to FIR DIN
VOUT  out  1  valid to FIR VIN
SAMPLE_IDX  out  AW  memory index of the sample currently on DOUT
BUSY  out  1  high in PLAY, GAP and DRAIN
END_SIM  out  1  playback complete, held high in DONE

Behaviour:
- One clock, CLK. RST_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, internal counters 0. Memory contents are not reset.
- States: IDLE, PLAY, GAP, DRAIN, DONE.
- IDLE/DONE:
  - WR_EN writes mem[WR_ADDR] <= WR_DATA at the edge.
  - START at edge k latches N = min(NUM_SAMPLES, 2**AW) and G = GAP, sets addr=0, clears END_SIM.
  - Next state is PLAY, or DRAIN if N=0.
- PLAY, PAUSE=0, at an edge:
  - DOUT<=mem[addr], SAMPLE_IDX<=addr, VOUT<=1, addr++, emitted++.
  - First valid sample appears after edge k+1.
  - Next state: DRAIN if emitted==N; else GAP if G>0; else PLAY (back-to-back valids).
- GAP: VOUT<=0, DOUT and SAMPLE_IDX hold. Counts G edges, then returns to PLAY. Exactly G idle cycles between consecutive valids.
- PAUSE=1 in PLAY or GAP: VOUT<=0 at the next edge, all counters frozen. Resumes where it left off on the first edge with PAUSE=0.
- DRAIN: VOUT=0. Counts DRAIN_CYCLES edges (PAUSE ignored), then DONE.
- DONE: END_SIM=1, BUSY=0. Stays until reset or a new START (restart).
- BUSY=1 in PLAY, GAP and DRAIN.
- START while BUSY is ignored. WR_EN while BUSY is ignored (memory unchanged).
- START and WR_EN in the same IDLE cycle: both take effect. The write lands at that edge; the first read occurs one edge later, so the new data is visible.
- Memory read is synchronous. Address wrap is impossible because N is clamped; addr never exceeds 2**AW-1.
- VOUT is high for exactly one cycle per sample. Total valids per run = N.
- Reset mid-run: immediate return to IDLE, VOUT=0, END_SIM=0.

Decomposition:
- Package fir_tb_pkg: NB, AW, state enumeration (IDLE, PLAY, GAP, DRAIN, DONE).
- One sub-module: fir_src_mem, a simple dual-port RAM of 2**AW x NB with one write port and a registered read port. Read data is registered directly into DOUT.
- FSM and counters live in fir_stream_source.

Test Plan:
- Load mem[0..3]=0x01,0x7F,0x80,0xFF; START with N=4, G=0 -> VOUT high 4 consecutive cycles starting edge k+1; DOUT=01,7F,80,FF; SAMPLE_IDX=0..3; END_SIM rises 16 edges after the last valid.
- Same data, G=2 -> valids on edges k+1, k+4, k+7, k+10; DOUT holds between valids; 4 valids total.
- N=4, G=0, PAUSE high for 3 cycles after the second sample -> exactly 3 extra idle cycles; sequence 01,7F,80,FF unchanged, no duplicate or lost sample.
- START with N=0 -> no VOUT; BUSY high for 16 cycles; END_SIM high after DRAIN; START pulses and WR_EN during that window ignored (memory readback unchanged).
- NUM_SAMPLES=2**AW+5 -> exactly 2**AW valids, SAMPLE_IDX ends at 2**AW-1; then START again from DONE -> END_SIM drops and a fresh run replays from index 0.
- RST_n asserted asynchronously mid-GAP -> VOUT, BUSY, END_SIM immediately 0; after release, START replays from index 0 with memory contents intact.
